serv_ibuf: RTL

//  Instruction prefetch buffer between the PC/control stage's instruction-bus request and the

---
 rtl/serv_ibuf.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/serv_ibuf.sv
// serv_ibuf: instruction fetch buffer between the core fetch port and a Wishbone bus.
// Sequential prefetch FIFO is built only when SERV_IBUF_PREFETCH_EN is defined.
module serv_ibuf #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_cpu_adr,
    input  logic        i_cpu_cyc,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

`ifdef SERV_IBUF_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PREFETCH,
        DISCARD
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [29:0]   next_adr;
    logic [29:0]   fetch_adr;
    logic [29:0]   wb_adr;
    logic [29:0]   cpu_adr;
    logic [29:0]   head_adr;
    logic          req;
    logic          hit;
    logic          inflight;
    logic          miss;
    logic          push;
    logic          unused_adr_bits;

    assign unused_adr_bits = ^i_cpu_adr[1:0];
    assign o_wb_adr = {wb_adr, 2'b00};
    assign cpu_adr  = i_cpu_adr[31:2];

    // FIFO words are consecutive and end just below the next prefetch target
    assign head_adr = next_adr - 30'(count);

    // A request being served by FETCH/DISCARD is not re-classified
    assign req = i_cpu_cyc && !o_cpu_ack &&
                 (state == IDLE || state == PREFETCH);
    assign hit = req && (count != '0) && (head_adr == cpu_adr);
    assign inflight = req && (count == '0) &&
                      (state == PREFETCH) && (wb_adr == cpu_adr);
    assign miss = req && !hit && !inflight;
    assign push = (state == PREFETCH) && i_wb_ack && !miss && !inflight;
    assign count_nxt = count + CW'(push) - CW'(hit);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wb_rdt;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            next_adr  <= RESET_PC[31:2];
            fetch_adr <= '0;
            wb_adr    <= '0;
            o_wb_cyc  <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_cpu_rdt <= '0;
        end else begin
            o_cpu_ack <= 1'b0;
            if (hit) begin
                o_cpu_ack <= 1'b1;
                o_cpu_rdt <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (miss) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                next_adr  <= cpu_adr + 30'd1;
                fetch_adr <= cpu_adr;
            end
            count <= miss ? '0 : count_nxt;
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        state    <= FETCH;
                        o_wb_cyc <= 1'b1;
                        wb_adr   <= cpu_adr;
                    end else if (PF_EN && count_nxt < FULL) begin
                        state    <= PREFETCH;
                        o_wb_cyc <= 1'b1;
                        wb_adr   <= next_adr;
                    end
                end
                FETCH: begin
                    if (i_wb_ack) begin
                        o_cpu_ack <= 1'b1;
                        o_cpu_rdt <= i_wb_rdt;
                        next_adr  <= wb_adr + 30'd1;
                        if (PF_EN) begin
                            state  <= PREFETCH;
                            wb_adr <= wb_adr + 30'd1;
                        end else begin
                            state    <= IDLE;
                            o_wb_cyc <= 1'b0;
                        end
                    end
                end
                PREFETCH: begin
                    if (miss) begin
                        // an ack landing with the miss frees the bus at once
                        if (i_wb_ack) begin
                            state  <= FETCH;
                            wb_adr <= cpu_adr;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (inflight) begin
                        if (i_wb_ack) begin
                            o_cpu_ack <= 1'b1;
                            o_cpu_rdt <= i_wb_rdt;
                            next_adr  <= next_adr + 30'd1;
                            wb_adr    <= next_adr + 30'd1;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (push) begin
                        next_adr <= next_adr + 30'd1;
                        if (count_nxt < FULL) begin
                            wb_adr <= next_adr + 30'd1;
                        end else begin
                            state    <= IDLE;
                            o_wb_cyc <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (i_wb_ack) begin
                        state  <= FETCH;
                        wb_adr <= fetch_adr;
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_wb_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule
